lfsr32_keystream: RTL and testbench

- 32-bit Galois LFSR keystream generator that sits directly upstream of xor32 and drives its b operand, one keystream word per accepted transfer, to encrypt or decrypt a 32-bit datapath word.
- Provides seed loading, a valid/ready handshake toward the consumer, and a count of delivered words so the downstream XOR stage and the controller stay in lockstep.

---
 rtl/lfsr32_keystream_if.sv | 30 +++
 rtl/lfsr32_keystream.sv | 107 ++++++++++
 tb/tb_lfsr32_keystream.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr32_keystream_if.sv
// Keystream handshake bundle between a controller/consumer and lfsr32_keystream.
//   master : controller side, drives seed/enable/ks_ready, observes keystream
//   slave  : generator side, observes control, drives ks_valid/ks_word/word_count
// Signals:
//   seed_load  - load seed this cycle (highest priority)
//   seed       - seed value, sampled with seed_load
//   enable     - request keystream generation
//   ks_ready   - consumer accepts ks_word this cycle
//   ks_valid   - ks_word holds a valid keystream word
//   ks_word    - registered keystream word
//   word_count - number of accepted words, wraps
interface lfsr32_keystream_if;
  logic        seed_load;
  logic [31:0] seed;
  logic        enable;
  logic        ks_ready;
  logic        ks_valid;
  logic [31:0] ks_word;
  logic [31:0] word_count;

  modport master (
    output seed_load, seed, enable, ks_ready,
    input  ks_valid, ks_word, word_count
  );

  modport slave (
    input  seed_load, seed, enable, ks_ready,
    output ks_valid, ks_word, word_count
  );
endinterface

// File: rtl/lfsr32_keystream.sv
// 32-bit Galois LFSR keystream generator feeding the b operand of xor32.
// One LFSR step per delivered word, valid/ready handshake toward the consumer,
// and a wrapping count of accepted words.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous, active-low reset
//   ks    - lfsr32_keystream_if.slave (seed_load, seed, enable, ks_ready in;
//           ks_valid, ks_word, word_count out, all registered)
module lfsr32_keystream #(
  parameter logic [31:0] POLY         = 32'h80200003,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE12468
) (
  input  logic              clk,
  input  logic              rst_n,
  lfsr32_keystream_if.slave ks
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] word_q, word_d;
  logic        vld_q, vld_d;
  logic [31:0] cnt_q, cnt_d;

  // Right-shift Galois step. The state can never reach zero: a zero seed is
  // replaced, and stepping a nonzero state always yields a nonzero state.
  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] safe_seed(input logic [31:0] s);
    return (s == 32'h0) ? DEFAULT_SEED : s;
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    word_d  = word_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;

    if (ks.seed_load) begin
      // Discards any pending word, even one being handshaked this cycle.
      lfsr_d  = safe_seed(ks.seed);
      word_d  = 32'h0;
      vld_d   = 1'b0;
      cnt_d   = 32'h0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          vld_d = 1'b0;
          if (ks.enable) state_d = GEN;
        end
        GEN: begin
          lfsr_d  = step(lfsr_q);
          word_d  = step(lfsr_q);
          vld_d   = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          // Word and valid stay frozen until the consumer takes the word.
          if (ks.ks_ready) begin
            cnt_d = cnt_q + 32'd1;
            if (ks.enable) begin
              lfsr_d = step(lfsr_q);
              word_d = step(lfsr_q);
            end else begin
              vld_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= DEFAULT_SEED;
      word_q  <= 32'h0;
      vld_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ks.ks_valid   = vld_q;
  assign ks.ks_word    = word_q;
  assign ks.word_count = cnt_q;

endmodule

// File: tb/tb_lfsr32_keystream.sv
// Scoreboard bench for lfsr32_keystream: stimulus pushes expected
// (word, count) pairs, a negedge monitor pops and compares on each handshake.
module tb_lfsr32_keystream;

  logic clk;
  logic rst_n;

  lfsr32_keystream_if ks_if ();

  lfsr32_keystream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cap_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] P = 32'h80200003;

  function automatic logic [31:0] model_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? P : 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] c);
    exp_t e;
    e.word = w;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: a word is delivered on valid & ready, unless seed_load discards it.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ks_if.ks_valid && ks_if.ks_ready && !ks_if.seed_load) begin
      cap_q.push_back(ks_if.ks_word);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h, required none", ks_if.ks_word);
      end else begin
        e = exp_q.pop_front();
        chk("ks_word", ks_if.ks_word, e.word);
        chk("word_count", ks_if.word_count, e.cnt);
      end
    end
  end

  task automatic load_seed(input logic [31:0] v);
    ks_if.seed_load = 1'b1;
    ks_if.seed      = v;
    @(posedge clk); #1;
    ks_if.seed_load = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ks_if.ks_valid) break;
    end
    chk("valid_wait", {31'h0, ks_if.ks_valid}, 32'h1);
  endtask

  // Stream n words with ks_ready held high, ending back in IDLE.
  task automatic stream(input int n);
    ks_if.enable   = 1'b1;
    ks_if.ks_ready = 1'b1;
    wait_valid();
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
    ks_if.enable = 1'b0;
    @(posedge clk); #1;
    ks_if.ks_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic [31:0] ct[4];
    rst_n           = 1'b0;
    ks_if.seed_load = 1'b0;
    ks_if.seed      = 32'h0;
    ks_if.enable    = 1'b0;
    ks_if.ks_ready  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, ks_if.ks_valid}, 32'h0);
    chk("rst_word", ks_if.ks_word, 32'h0);
    chk("rst_count", ks_if.word_count, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Seed 1, streaming with latency check
    load_seed(32'h1);
    push(32'h80200003, 0);
    push(32'hC0300002, 1);
    push(32'h60180001, 2);
    ks_if.enable   = 1'b1;
    ks_if.ks_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("latency_one_edge", {31'h0, ks_if.ks_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_two_edges", {31'h0, ks_if.ks_valid}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ks_if.enable = 1'b0;
    @(posedge clk); #1;
    ks_if.ks_ready = 1'b0;
    @(negedge clk);
    chk("idle_valid", {31'h0, ks_if.ks_valid}, 32'h0);
    chk("count_after_3", ks_if.word_count, 32'h3);

    // Backpressure; enable and seed bus wiggle during the stall
    @(posedge clk); #1;
    load_seed(32'h1);
    push(32'h80200003, 0);
    push(32'hC0300002, 1);
    ks_if.enable   = 1'b1;
    ks_if.ks_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      ks_if.enable = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      ks_if.seed   = 32'h1234_0000 + i;
      @(negedge clk);
      chk("stall_word", ks_if.ks_word, 32'h80200003);
      chk("stall_count", ks_if.word_count, 32'h0);
      chk("stall_valid", {31'h0, ks_if.ks_valid}, 32'h1);
      @(posedge clk); #1;
    end
    ks_if.enable   = 1'b1;
    ks_if.ks_ready = 1'b1;
    @(posedge clk); #1;
    ks_if.enable = 1'b0;
    @(posedge clk); #1;
    ks_if.ks_ready = 1'b0;

    // Zero seed falls back to DEFAULT_SEED (0xACE12468 is even, so step is a shift)
    load_seed(32'h0);
    push(32'h56709234, 0);
    push(32'h2B38491A, 1);
    stream(2);

    // Seed load during a live handshake discards the pending word
    load_seed(32'h1);
    push(32'h80200003, 0);
    ks_if.enable   = 1'b1;
    ks_if.ks_ready = 1'b0;
    wait_valid();
    ks_if.ks_ready = 1'b1;
    @(posedge clk); #1;
    ks_if.seed_load = 1'b1;
    ks_if.seed      = 32'h1;
    @(posedge clk); #1;
    ks_if.seed_load = 1'b0;
    ks_if.enable    = 1'b0;
    ks_if.ks_ready  = 1'b0;
    @(negedge clk);
    chk("sl_valid", {31'h0, ks_if.ks_valid}, 32'h0);
    chk("sl_count", ks_if.word_count, 32'h0);
    chk("sl_word", ks_if.ks_word, 32'h0);
    @(posedge clk); #1;
    push(32'h80200003, 0);
    push(32'hC0300002, 1);
    stream(2);

    // Asynchronous reset mid-stream
    load_seed(32'h1);
    push(32'h80200003, 0);
    push(32'hC0300002, 1);
    ks_if.enable   = 1'b1;
    ks_if.ks_ready = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, ks_if.ks_valid}, 32'h0);
    chk("arst_word", ks_if.ks_word, 32'h0);
    chk("arst_count", ks_if.word_count, 32'h0);
    ks_if.enable   = 1'b0;
    ks_if.ks_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(32'h56709234, 0);
    push(32'h2B38491A, 1);
    stream(2);

    // End to end: encrypt then decrypt with the identical reseeded stream
    for (int p = 0; p < 2; p++) begin
      cap_q.delete();
      load_seed(32'h1);
      s = 32'h1;
      for (int k = 0; k < 4; k++) begin
        s = model_step(s);
        push(s, k);
      end
      stream(4);
      for (int k = 0; k < 4; k++) begin
        if (p == 0) ct[k] = 32'hCAFEBABE ^ ((k < cap_q.size()) ? cap_q[k] : 32'h0);
        else chk("e2e_recover", ct[k] ^ ((k < cap_q.size()) ? cap_q[k] : 32'h0), 32'hCAFEBABE);
      end
    end

    repeat (2) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
